multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle successor to the single-cycle main decoder: a Moore FSM that sequences RV32I
//  R/I-ALU/lw/sw/beq/jal instructions over several cycles with a variable-latency memory
//  handshake. It drives the datapath muxes, write enables and ALUOp (2'b00 add, 2'b01 sub/beq,
//  2'b10 funct-decoded), flags illegal opcodes, and traps on memory timeout.
// PARAMETERS
//  TIMEOUT_CYC  16  max wait cycles for mem_ready per access; 0 disables the timeout
//  CNT_W        32  width of perf counters (MC_CTRL_PERF_EN only)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  op           in   7      opcode from instruction register
//  zero         in   1      ALU zero flag (beq)
//  mem_ready    in   1      memory accepted/returned the current access this cycle
//  mem_req      out  1      memory access request, held high until mem_ready
//  mem_write    out  1      request is a store (valid with mem_req)
//  adr_src      out  1      0 = PC, 1 = ALU result as memory address
//  ir_write     out  1      latch fetched instruction
//  pc_write     out  1      update PC (fetch increment, taken beq, jal)
//  reg_write    out  1      register-file write enable
//  alu_src_a    out  2      00 PC, 01 old PC, 10 rs1
//  alu_src_b    out  2      00 rs2, 01 imm, 10 constant 4
//  result_src   out  2      00 ALU out, 01 mem data, 10 ALU result (bypass)
//  alu_op       out  2      to ALU decoder
//  illegal      out  1      sticky: unsupported opcode decoded
//  bus_err      out  1      sticky: memory timeout
//  state_o      out  4      current state encoding (debug)
// BEHAVIOUR
//  - States: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB,
//    BEQ, JAL, TRAP. Outputs are decoded from the state register; ir_write, pc_write (FETCH)
//    and the MEMREAD->MEMWB and MEMWRITE->FETCH advances are gated by mem_ready.
//  - Reset: state=IDLE; all outputs 0; wait counter 0. IDLE->FETCH on the first clock after release.
//  - FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00. When mem_ready=1:
//    ir_write=1 and pc_write=1 in that same cycle, then DECODE. Otherwise hold with no side effects.
//  - DECODE (1 cycle): alu_src_a=01, alu_src_b=01 (branch target precompute). Next state by op:
//    0000011/0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BEQ;
//    1101111 -> JAL; any other -> TRAP with illegal set.
//  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; -> MEMREAD (lw) or MEMWRITE (sw).
//  - MEMREAD: mem_req=1, adr_src=1; on mem_ready -> MEMWB. MEMWB: result_src=01, reg_write=1 -> FETCH.
//  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1; on mem_ready -> FETCH.
//  - EXEC_R: src_a=10, src_b=00, alu_op=10 -> ALUWB. EXEC_I: src_a=10, src_b=01, alu_op=10 -> ALUWB.
//  - ALUWB: result_src=00, reg_write=1 -> FETCH.
//  - BEQ: src_a=10, src_b=00, alu_op=01, result_src=00; pc_write=zero -> FETCH.
//  - JAL: src_a=01, src_b=10, result_src=00, reg_write=1, pc_write=1 -> FETCH.
//  - Latency with 0-wait memory: R/I 4, lw 5, sw 4, beq 3, jal 3 cycles.
//  - Timeout: the wait counter clears on entry to FETCH/MEMREAD/MEMWRITE and increments each
//    cycle mem_req=1 && mem_ready=0. If it reaches TIMEOUT_CYC, the next state is TRAP and bus_err
//    is set. mem_ready arriving on that same cycle wins: it is a normal completion, not a timeout.
//  - TRAP: all enables 0, mem_req=0; held until reset. illegal/bus_err clear only on reset.
//  - mem_ready while mem_req=0 is ignored. Reset asserted mid-access drops mem_req asynchronously.
// CONFIGURATION
//  MC_CTRL_PERF_EN defined: adds outputs cycle_cnt[CNT_W] (increments every cycle outside IDLE/TRAP)
//   and instret_cnt[CNT_W] (increments on each transition into FETCH from a completing state).
//   Both wrap modulo 2^CNT_W and reset to 0. Undefined: neither port nor counter exists.
// STRUCTURE
//  - mc_ctrl_pkg: opcode localparams, state_e enum (4-bit), ALUOp / src-mux / result_src encodings.
//  - Sub-module mc_ctrl_out_decode: combinational state_e -> control word, instantiated once.
//  - Top module: state register, next-state logic, wait counter, sticky flags, optional counters.
// TESTING
//  - Reset then lw (op=0000011), mem_ready=1 always -> IDLE,FETCH,DECODE,MEMADR,MEMREAD,MEMWB;
//    reg_write=1 only in MEMWB with result_src=01.
//  - R-type, mem_ready held low for 3 FETCH cycles -> mem_req high 4 cycles; ir_write/pc_write
//    pulse exactly once, on the mem_ready cycle.
//  - beq with zero=1 then zero=0 -> pc_write=1 in BEQ only for the first; alu_op=01 in both.
//  - op=1110011 -> TRAP after DECODE, illegal=1, all enables 0 for 10 cycles; rst_n low clears it.
//  - TIMEOUT_CYC=4, sw with mem_ready never asserted -> TRAP after 4 wait cycles, bus_err=1;
//    repeat with mem_ready on the 4th cycle -> FETCH, bus_err=0.
//  - MC_CTRL_PERF_EN: 3 back-to-back addi -> instret_cnt=3, cycle_cnt=12 (counted from the first FETCH).

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM:
// opcodes, state encoding, mux/ALUOp encodings and the control word.
package mc_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC_R   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [6:0] op);
        return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
    endfunction

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// Moore output decode: state -> datapath control word.
// FETCH strobes and the BEQ pc update are qualified by mem_ready/zero.
module mc_ctrl_out_decode
    import mc_ctrl_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    input  logic   zero,
    output ctrl_t  ctrl
);

    // Everything defaults to 0 so IDLE and TRAP drive no enables.
    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_MEM;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.adr_src   = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = zero;
            end
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.pc_write   = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM with memory wait timeout and sticky traps.
// Define MC_CTRL_PERF_EN to add cycle_cnt / instret_cnt counters.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state_o
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit TO_EN  = (TIMEOUT_CYC > 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        TO_EN ? WAIT_W'(TIMEOUT_CYC - 1) : '0;

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("CNT_W must be positive");
    end

    state_e            state;
    state_e            state_n;
    ctrl_t             ctrl;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout;
    logic              dec_bad;

    mc_ctrl_out_decode u_dec (
        .state     (state),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (ctrl)
    );

    // A wait that would reach the limit traps; a same-cycle ready wins.
    assign timeout = TO_EN && ctrl.mem_req && !mem_ready
                     && (wait_cnt == WAIT_LAST);
    assign dec_bad = (state == S_DECODE) && !op_legal(op);

    // Next-state: sequence the instruction, divert to TRAP on timeout.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:     state_n = S_FETCH;
            S_FETCH:    if (mem_ready) state_n = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_R:         state_n = S_EXEC_R;
                    OP_I:         state_n = S_EXEC_I;
                    OP_BEQ:       state_n = S_BEQ;
                    OP_JAL:       state_n = S_JAL;
                    default:      state_n = S_TRAP;
                endcase
            end
            S_MEMADR:
                state_n = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_n = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_n = S_FETCH;
            S_EXEC_R,
            S_EXEC_I:   state_n = S_ALUWB;
            S_MEMWB,
            S_ALUWB,
            S_BEQ,
            S_JAL:      state_n = S_FETCH;
            S_TRAP:     state_n = S_TRAP;
            default:    state_n = S_IDLE;
        endcase
        if (timeout) state_n = S_TRAP;
    end

    // State register and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state <= state_n;
            if (dec_bad) illegal <= 1'b1;
            if (timeout) bus_err <= 1'b1;
        end
    end

    // Wait counter restarts whenever the state changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_n != state) begin
            wait_cnt <= '0;
        end else if (ctrl.mem_req && !mem_ready) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

`ifdef MC_CTRL_PERF_EN
    // Active cycles and retired instructions (completion into FETCH).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != S_IDLE && state != S_TRAP)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (state_n == S_FETCH && state != S_FETCH && state != S_IDLE)
                instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`endif

    assign mem_req    = ctrl.mem_req;
    assign mem_write  = ctrl.mem_write;
    assign adr_src    = ctrl.adr_src;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign result_src = ctrl.result_src;
    assign alu_op     = ctrl.alu_op;
    assign state_o    = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed scenarios plus random
// instruction/memory-latency streams against a step-list reference model.
module tb_multicycle_control_fsm;
    import mc_ctrl_pkg::*;

    localparam int TO = 4;
    localparam int CW = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic       illegal, bus_err;
    logic [3:0] state_o;
`ifdef MC_CTRL_PERF_EN
    logic [CW-1:0] cycle_cnt, instret_cnt;
`endif

    multicycle_control_fsm #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
        .illegal(illegal), .bus_err(bus_err), .state_o(state_o)
`ifdef MC_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [13:0] got;
    assign got = {mem_req, mem_write, adr_src, ir_write, pc_write,
                  reg_write, alu_src_a, alu_src_b, result_src, alu_op};

    typedef state_e path_t[$];

    int checks = 0;
    int errors = 0;

    state_e        m_cur;
    path_t         m_path;
    int            m_wait;
    bit            m_ill, m_berr, m_zero;
    logic [6:0]    m_op;
    logic [CW-1:0] m_cyc, m_ins;
    logic [6:0]    op_q[$];
    bit            rdy_q[$];
    bit            zero_q[$];
    int            n_irw, n_pcw, n_regw, n_memreq, trap_cyc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] cw(
        input bit req, input bit wr, input bit adr, input bit irw,
        input bit pcw, input bit regw, input logic [1:0] a,
        input logic [1:0] b, input logic [1:0] rs, input logic [1:0] aop);
        return {req, wr, adr, irw, pcw, regw, a, b, rs, aop};
    endfunction

    // Control word each step must present, straight from the step table.
    function automatic logic [13:0] exp_ctrl(input state_e s, input bit r,
                                             input bit z);
        case (s)
            S_FETCH:    return cw(1,0,0,r,r,0, 2'b00,2'b10,2'b00,2'b00);
            S_DECODE:   return cw(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00);
            S_MEMADR:   return cw(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00);
            S_MEMREAD:  return cw(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00);
            S_MEMWB:    return cw(0,0,0,0,0,1, 2'b00,2'b00,2'b01,2'b00);
            S_MEMWRITE: return cw(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00);
            S_EXEC_R:   return cw(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10);
            S_EXEC_I:   return cw(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b10);
            S_ALUWB:    return cw(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00);
            S_BEQ:      return cw(0,0,0,0,z,0, 2'b10,2'b00,2'b00,2'b01);
            S_JAL:      return cw(0,0,0,0,1,1, 2'b01,2'b10,2'b00,2'b00);
            default:    return '0;
        endcase
    endfunction

    // Steps an instruction walks through after FETCH.
    function automatic path_t steps_for(input logic [6:0] o);
        path_t p;
        p.push_back(S_DECODE);
        case (o)
            OP_LW: begin
                p.push_back(S_MEMADR);
                p.push_back(S_MEMREAD);
                p.push_back(S_MEMWB);
            end
            OP_SW: begin
                p.push_back(S_MEMADR);
                p.push_back(S_MEMWRITE);
            end
            OP_R: begin
                p.push_back(S_EXEC_R);
                p.push_back(S_ALUWB);
            end
            OP_I: begin
                p.push_back(S_EXEC_I);
                p.push_back(S_ALUWB);
            end
            OP_BEQ:  p.push_back(S_BEQ);
            OP_JAL:  p.push_back(S_JAL);
            default: p.push_back(S_TRAP);
        endcase
        return p;
    endfunction

    function automatic logic [6:0] rand_op();
        logic [6:0] v;
        int r = $urandom_range(0, 15);
        if (r < 2) return OP_LW;
        if (r < 4) return OP_SW;
        if (r < 7) return OP_R;
        if (r < 10) return OP_I;
        if (r < 12) return OP_BEQ;
        if (r < 15) return OP_JAL;
        do v = 7'($urandom_range(0, 127));
        while (v inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});
        return v;
    endfunction

    task automatic start_instr();
        m_op   = (op_q.size() != 0) ? op_q.pop_front() : rand_op();
        m_zero = (zero_q.size() != 0) ? zero_q.pop_front()
                                      : 1'($urandom_range(0, 1));
        m_path = steps_for(m_op);
        m_cur  = S_FETCH;
        m_wait = 0;
    endtask

    // Reference advance across one rising edge.
    task automatic model_step(input bit r);
        bit waiting;
        if (m_cur == S_TRAP) return;
        if (m_cur != S_IDLE) m_cyc++;
        waiting = (m_cur inside {S_FETCH, S_MEMREAD, S_MEMWRITE}) && !r;
        if (waiting) begin
            m_wait++;
            if (TO != 0 && m_wait >= TO) begin
                m_cur  = S_TRAP;
                m_berr = 1'b1;
            end
            return;
        end
        if (m_path.size() == 0) begin
            if (m_cur != S_IDLE) m_ins++;
            start_instr();
        end else begin
            m_cur  = m_path.pop_front();
            m_wait = 0;
            if (m_cur == S_TRAP) m_ill = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_cur = S_IDLE;
        m_path.delete();
        op_q.delete();
        rdy_q.delete();
        zero_q.delete();
        m_wait = 0;
        m_ill = 0;
        m_berr = 0;
        m_op = '0;
        m_zero = 0;
        m_cyc = '0;
        m_ins = '0;
        n_irw = 0;
        n_pcw = 0;
        n_regw = 0;
        n_memreq = 0;
        trap_cyc = 0;
    endtask

    // Called at a falling edge; asserts reset, checks, releases.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl", 32'(got), 32'd0);
        chk("rst_state", 32'(state_o), 32'(S_IDLE));
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
`ifdef MC_CTRL_PERF_EN
        chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
        chk("rst_instret", 32'(instret_cnt), 32'd0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_cycle();
        logic [13:0] e;
        mem_ready = (rdy_q.size() != 0) ? rdy_q.pop_front()
                                        : ($urandom_range(0, 9) < 6);
        op   = m_op;
        zero = m_zero;
        #1;
        e = exp_ctrl(m_cur, mem_ready, m_zero);
        chk("ctrl", 32'(got), 32'(e));
        chk("state", 32'(state_o), 32'(m_cur));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("bus_err", 32'(bus_err), 32'(m_berr));
`ifdef MC_CTRL_PERF_EN
        chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cyc));
        chk("instret_cnt", 32'(instret_cnt), 32'(m_ins));
`endif
        n_irw    += int'(ir_write);
        n_pcw    += int'(pc_write);
        n_regw   += int'(reg_write);
        n_memreq += int'(mem_req);
        model_step(mem_ready);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit auto_rst);
        for (int i = 0; i < n; i++) begin
            do_cycle();
            if (auto_rst) begin
                trap_cyc = (m_cur == S_TRAP) ? trap_cyc + 1 : 0;
                if (trap_cyc >= 10) apply_reset();
            end
        end
    endtask

    task automatic push_rdy(input int n, input bit v);
        for (int i = 0; i < n; i++) rdy_q.push_back(v);
    endtask

    initial begin
        @(negedge clk);
        apply_reset();

        // lw, zero-wait memory.
        op_q.push_back(OP_LW);
        push_rdy(6, 1'b1);
        run(6, 1'b0);
        chk("lw_regw_cycles", 32'(n_regw), 32'd1);

        // R-type with three FETCH stall cycles.
        apply_reset();
        op_q.push_back(OP_R);
        push_rdy(1, 1'b1);
        push_rdy(3, 1'b0);
        push_rdy(4, 1'b1);
        run(8, 1'b0);
        chk("r_memreq_cycles", 32'(n_memreq), 32'd4);
        chk("r_irw_pulses", 32'(n_irw), 32'd1);
        chk("r_pcw_pulses", 32'(n_pcw), 32'd1);

        // beq taken then not taken.
        apply_reset();
        op_q.push_back(OP_BEQ);
        op_q.push_back(OP_BEQ);
        zero_q.push_back(1'b1);
        zero_q.push_back(1'b0);
        push_rdy(7, 1'b1);
        run(7, 1'b0);
        chk("beq_pcw_pulses", 32'(n_pcw), 32'd3);

        // Illegal opcode traps and stays there.
        apply_reset();
        op_q.push_back(7'b1110011);
        push_rdy(13, 1'b1);
        run(13, 1'b0);
        chk("illegal_set", 32'(illegal), 32'd1);
        chk("illegal_enables", 32'(n_irw + n_regw), 32'd1);

        // sw with memory never ready: timeout.
        apply_reset();
        op_q.push_back(OP_SW);
        push_rdy(4, 1'b1);
        push_rdy(4, 1'b0);
        push_rdy(3, 1'b1);
        run(11, 1'b0);
        chk("sw_to_bus_err", 32'(bus_err), 32'd1);
        chk("sw_to_state", 32'(state_o), 32'(S_TRAP));

        // sw with ready on the last allowed wait cycle.
        apply_reset();
        op_q.push_back(OP_SW);
        push_rdy(4, 1'b1);
        push_rdy(3, 1'b0);
        push_rdy(1, 1'b1);
        run(8, 1'b0);
        chk("sw_late_state", 32'(state_o), 32'(S_FETCH));
        chk("sw_late_bus_err", 32'(bus_err), 32'd0);

        // Reset in the middle of a stalled fetch.
        apply_reset();
        op_q.push_back(OP_R);
        push_rdy(1, 1'b1);
        push_rdy(2, 1'b0);
        run(3, 1'b0);
        chk("mid_memreq_high", 32'(mem_req), 32'd1);
        apply_reset();

        // Three back-to-back addi.
        op_q.push_back(OP_I);
        op_q.push_back(OP_I);
        op_q.push_back(OP_I);
        push_rdy(13, 1'b1);
        run(13, 1'b0);
        chk("addi3_state", 32'(state_o), 32'(S_FETCH));
`ifdef MC_CTRL_PERF_EN
        chk("addi3_instret", 32'(instret_cnt), 32'd3);
        chk("addi3_cycles", 32'(cycle_cnt), 32'd12);
`endif

        // Random instruction mix and memory latency.
        apply_reset();
        run(3000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
